// File: rtl/logistic_mu_sweep_if.sv
// Parameter/handshake bundle between the video-timing/UI side (master)
// and the mu sweep controller (slave).
interface logistic_mu_sweep_if;
  logic        frame_start;
  logic        pause_sw;
  logic        btn_up;
  logic        btn_down;
  logic [1:0]  step_sel;
  logic [8:0]  repeat_in;
  logic [17:0] mu;
  logic [8:0]  maxrepeat;
  logic        iter_rst_n;
  logic        dir;
  logic        busy;

  modport master (
    output frame_start, pause_sw, btn_up, btn_down, step_sel, repeat_in,
    input  mu, maxrepeat, iter_rst_n, dir, busy
  );

  modport slave (
    input  frame_start, pause_sw, btn_up, btn_down, step_sel, repeat_in,
    output mu, maxrepeat, iter_rst_n, dir, busy
  );
endinterface

// File: rtl/logistic_mu_sweep.sv
// Frame-synchronous mu / maxrepeat generator for the logistic-map iterators,
// with ping-pong auto sweep, manual stepping and an iterator restart pulse.
module logistic_mu_sweep #(
  parameter logic [17:0] MU_MIN         = 18'h2_0000,
  parameter logic [17:0] MU_MAX         = 18'h3_FFC0,
  parameter logic [17:0] STEP_BASE      = 18'h0_0040,
  parameter int unsigned FRAME_DIV      = 4,
  parameter int unsigned RESTART_CYCLES = 4,
  parameter logic [8:0]  REPEAT_INIT    = 9'd100
) (
  input  logic               CLK,
  input  logic               RST,
  logistic_mu_sweep_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_RESTART = 2'd2
  } state_e;

  localparam logic [7:0] FDIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [3:0] RCNT_INIT = 4'(RESTART_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [17:0] mu_q, mu_d;
  logic [8:0]  rep_q, rep_d;
  logic        dir_q, dir_d;
  logic        iter_rst_n_q, iter_rst_n_d;
  logic        busy_q, busy_d;
  logic        up_prev_q, up_prev_d;
  logic        down_prev_q, down_prev_d;
  logic        pend_up_q, pend_up_d;
  logic        pend_down_q, pend_down_d;

  logic [17:0]        step_s;
  logic [18:0]        sum_s;
  logic signed [18:0] diff_s;
  logic               over_s, under_s;
  logic [8:0]         rep_new_s;
  logic [17:0]        mu_new_s;
  logic               dir_new_s;
  logic [7:0]         fcnt_new_s;
  logic               changed_s;
  logic               up_rise_s, down_rise_s;

  // Candidate parameter values that UPDATE would commit this cycle.
  always_comb begin
    step_s     = STEP_BASE << bus.step_sel;
    sum_s      = {1'b0, mu_q} + {1'b0, step_s};
    diff_s     = $signed({1'b0, mu_q}) - $signed({1'b0, step_s});
    over_s     = (sum_s > {1'b0, MU_MAX});
    under_s    = (diff_s < $signed({1'b0, MU_MIN}));
    rep_new_s  = (bus.repeat_in == 9'd0) ? 9'd1 : bus.repeat_in;
    mu_new_s   = mu_q;
    dir_new_s  = dir_q;
    fcnt_new_s = fcnt_q;
    if (bus.pause_sw) begin
      fcnt_new_s = 8'd0;
      if (pend_up_q && !pend_down_q) begin
        mu_new_s = over_s ? MU_MAX : sum_s[17:0];
      end else if (pend_down_q && !pend_up_q) begin
        mu_new_s = under_s ? MU_MIN : diff_s[17:0];
      end else begin
        mu_new_s = mu_q;
      end
    end else if (fcnt_q >= FDIV_LAST) begin
      fcnt_new_s = 8'd0;
      // Landing exactly on a bound keeps dir; the flip waits for the next move.
      if (dir_q) begin
        if (over_s) begin
          mu_new_s  = MU_MAX;
          dir_new_s = 1'b0;
        end else begin
          mu_new_s  = sum_s[17:0];
          dir_new_s = 1'b1;
        end
      end else begin
        if (under_s) begin
          mu_new_s  = MU_MIN;
          dir_new_s = 1'b1;
        end else begin
          mu_new_s  = diff_s[17:0];
          dir_new_s = 1'b0;
        end
      end
    end else begin
      fcnt_new_s = fcnt_q + 8'd1;
    end
    changed_s = (mu_new_s != mu_q) || (rep_new_s != rep_q);
  end

  // Next-state logic; frame_start outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (changed_s) begin
          state_d = ST_RESTART;
          rcnt_d  = RCNT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESTART: begin
        if (rcnt_q <= 4'd1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESTART;
          rcnt_d  = rcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rcnt_d  = 4'd0;
      end
    endcase
  end

  // Output and datapath register inputs.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    iter_rst_n_d = (state_d != ST_RESTART);
    up_prev_d    = bus.btn_up;
    down_prev_d  = bus.btn_down;
    up_rise_s    = bus.btn_up & ~up_prev_q;
    down_rise_s  = bus.btn_down & ~down_prev_q;
    if (state_q == ST_UPDATE) begin
      mu_d        = mu_new_s;
      rep_d       = rep_new_s;
      dir_d       = dir_new_s;
      fcnt_d      = fcnt_new_s;
      pend_up_d   = up_rise_s;
      pend_down_d = down_rise_s;
    end else begin
      mu_d        = mu_q;
      rep_d       = rep_q;
      dir_d       = dir_q;
      fcnt_d      = fcnt_q;
      pend_up_d   = pend_up_q | up_rise_s;
      pend_down_d = pend_down_q | down_rise_s;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RESTART;
      rcnt_q  <= RCNT_INIT;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mu_q         <= MU_MIN;
      rep_q        <= REPEAT_INIT;
      dir_q        <= 1'b1;
      fcnt_q       <= 8'd0;
      iter_rst_n_q <= 1'b0;
      busy_q       <= 1'b1;
      // Track the live level so a button held through reset is not an edge.
      up_prev_q    <= bus.btn_up;
      down_prev_q  <= bus.btn_down;
      pend_up_q    <= 1'b0;
      pend_down_q  <= 1'b0;
    end else begin
      mu_q         <= mu_d;
      rep_q        <= rep_d;
      dir_q        <= dir_d;
      fcnt_q       <= fcnt_d;
      iter_rst_n_q <= iter_rst_n_d;
      busy_q       <= busy_d;
      up_prev_q    <= up_prev_d;
      down_prev_q  <= down_prev_d;
      pend_up_q    <= pend_up_d;
      pend_down_q  <= pend_down_d;
    end
  end

  assign bus.mu         = mu_q;
  assign bus.maxrepeat  = rep_q;
  assign bus.iter_rst_n = iter_rst_n_q;
  assign bus.dir        = dir_q;
  assign bus.busy       = busy_q;

endmodule
